// File: rtl/fifo_pkg.sv
// Shared types, defaults and width helpers for the flagged synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit over the pointer so the full-depth occupancy fits.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read address, no reset.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO using all DEPTH entries, with threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc_s, rd_acc_s;
  logic [WIDTH-1:0] ram_rdata_s;
  fifo_status_t     status_s;

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata_s)
  );

  // Flags come only from registered count and error state.
  always_comb begin
    status_s              = '0;
    status_s.full         = (count_q == CW'(DEPTH));
    status_s.almost_full  = (count_q >= CW'(AF_THRESH));
    status_s.empty        = (count_q == CW'(0));
    status_s.almost_empty = (count_q <= CW'(AE_THRESH));
    status_s.overflow     = overflow_q;
    status_s.underflow    = underflow_q;
  end

  assign full         = status_s.full;
  assign almost_full  = status_s.almost_full;
  assign empty        = status_s.empty;
  assign almost_empty = status_s.almost_empty;
  assign overflow     = status_s.overflow;
  assign underflow    = status_s.underflow;
  assign count        = count_q;

  assign wr_acc_s = wr_en & ~status_s.full;
  assign rd_acc_s = rd_en & ~status_s.empty;

  // Next-state for pointers, occupancy and sticky errors; a new error beats err_clr.
  always_comb begin
    wr_ptr_d    = wr_acc_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d    = rd_acc_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d     = count_q;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d  = (wr_en & status_s.full)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & status_s.empty) | (underflow_q & ~err_clr);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; zero while empty so reset reads back as 0.
  assign rd_data  = status_s.empty ? '0 : ram_rdata_s;
  assign rd_valid = ~status_s.empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Read data holds between accepted reads; valid is a single-cycle pulse.
  always_comb begin
    rd_data_d  = rd_acc_s ? ram_rdata_s : rd_data_q;
    rd_valid_d = rd_acc_s;
  end

  // Read output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised self-checking bench for sync_fifo_flags against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, err_clr;
  logic [15:0] wr_data, rd_data;
  logic        full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic        exp_ovf, exp_unf, exp_rv;
  logic [15:0] exp_rd;

  sync_fifo_flags #(.WIDTH(16), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    exp_rv  = 1'b0;
    exp_rd  = 16'h0000;
  endtask

  // One clock of stimulus; the model is advanced from the occupancy seen before the edge.
  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
    int          sz;
    logic        wacc, racc;
    logic [15:0] popped;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    sz      = q.size();
    wacc    = w && (sz < DEPTH);
    racc    = r && (sz > 0);
    exp_ovf = (w && sz == DEPTH) || (exp_ovf && !c);
    exp_unf = (r && sz == 0) || (exp_unf && !c);
    popped  = 16'h0000;
    if (racc) popped = q.pop_front();
    if (wacc) q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    exp_rv = (q.size() > 0);
    exp_rd = exp_rv ? q[0] : 16'h0000;
`else
    exp_rv = racc;
    if (racc) exp_rd = popped;
`endif
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got %b want 1100", {empty, almost_empty, full, almost_full}); end
    checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL reset_valid_err: got %b want 000", {rd_valid, overflow, underflow}); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if ({count, empty, rd_valid} !== {4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL idle_after_reset: got %0d/%b/%b want 0/1/0", count, empty, rd_valid); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i); end
      checks++; if (almost_empty !== (i <= AET)) begin errors++; $display("FAIL fill_ae at %0d: got %b want %b", i, almost_empty, (i <= AET)); end
      checks++; if (almost_full !== (i >= AFT)) begin errors++; $display("FAIL fill_af at %0d: got %b want %b", i, almost_full, (i >= AFT)); end
      checks++; if ({full, empty} !== {(i == DEPTH), 1'b0}) begin errors++; $display("FAIL fill_full_empty at %0d: got %b%b", i, full, empty); end
    end
    step(1'b1, 16'h0009, 1'b0, 1'b0);
    checks++; if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin errors++; $display("FAIL overflow_write: got %0d/%b/%b want 8/1/1", count, full, overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      checks++; if (count !== 4'(DEPTH - i)) begin errors++; $display("FAIL drain_count: got %0d want %0d", count, DEPTH - i); end
      checks++; if ({rd_valid, rd_data} !== {exp_rv, exp_rd}) begin errors++; $display("FAIL drain_data %0d: got %b/%h want %b/%h", i, rd_valid, rd_data, exp_rv, exp_rd); end
`ifndef SYNC_FIFO_FWFT_EN
      checks++; if (rd_data !== 16'(i)) begin errors++; $display("FAIL drain_order %0d: got %h want %h", i, rd_data, 16'(i)); end
`endif
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if ({empty, underflow, rd_valid} !== 3'b110) begin errors++; $display("FAIL underflow_read: got %b want 110", {empty, underflow, rd_valid}); end
    step(1'b0, 16'h0, 1'b1, 1'b1);
    checks++; if ({overflow, underflow} !== 2'b01) begin errors++; $display("FAIL set_beats_clear: got %b want 01", {overflow, underflow}); end
    step(1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checks++; if ({count, overflow} !== {4'd7, 1'b1}) begin errors++; $display("FAIL full_rw: got %0d/%b want 7/1", count, overflow); end
    checks++; if ({rd_valid, rd_data} !== {exp_rv, exp_rd}) begin errors++; $display("FAIL full_rw_data: got %b/%h want %b/%h", rd_valid, rd_data, exp_rv, exp_rd); end
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h0055, 1'b1, 1'b0);
    checks++; if ({count, underflow, overflow} !== {4'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL empty_rw: got %0d/%b/%b want 1/1/0", count, underflow, overflow); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'($urandom), 1'b1, 1'b0);
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL stream_count %0d: got %0d want 1", i, count); end
      checks++; if ({rd_valid, rd_data} !== {exp_rv, exp_rd}) begin errors++; $display("FAIL stream_data %0d: got %b/%h want %b/%h", i, rd_valid, rd_data, exp_rv, exp_rd); end
    end
  endtask

  task automatic test_random();
    int pw;
    for (int i = 0; i < 300; i++) begin
      pw = (i < 100) ? 75 : ((i < 200) ? 25 : 50);
      step(($urandom_range(99) < pw), 16'($urandom), ($urandom_range(99) < (100 - pw)), ($urandom_range(15) == 0));
      checks++;
      if ({count, full, almost_full, empty, almost_empty, overflow, underflow} !==
          {4'(q.size()), (q.size() == DEPTH), (q.size() >= AFT), (q.size() == 0), (q.size() <= AET), exp_ovf, exp_unf}) begin
        errors++;
        $display("FAIL random_status %0d: got cnt=%0d f=%b af=%b e=%b ae=%b ov=%b un=%b want cnt=%0d ov=%b un=%b",
                 i, count, full, almost_full, empty, almost_empty, overflow, underflow, q.size(), exp_ovf, exp_unf);
      end
      checks++; if ({rd_valid, rd_data} !== {exp_rv, exp_rd}) begin errors++; $display("FAIL random_read %0d: got %b/%h want %b/%h", i, rd_valid, rd_data, exp_rv, exp_rd); end
    end
  endtask

  task automatic test_reset_mid();
    while (q.size() > 0) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h2000, 1'b1, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count: got %0d want 5", count); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", count); end
    checks++; if ({empty, almost_empty, full, almost_full, overflow, underflow, rd_valid} !== 7'b1100000) begin errors++; $display("FAIL midreset_flags: got %b want 1100000", {empty, almost_empty, full, almost_full, overflow, underflow, rd_valid}); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL midreset_rd_data: got %h want 0000", rd_data); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if ({rd_valid, rd_data} !== {1'b1, 16'h00AA}) begin errors++; $display("FAIL post_reset_first: got %b/%h want 1/00aa", rd_valid, rd_data); end
`endif
    checks++; if ({count, empty} !== {4'd0, 1'b1}) begin errors++; $display("FAIL post_reset_empty: got %0d/%b want 0/1", count, empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_stream();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
